serial_multiplier: RTL
======================

// Module: serial_multiplier
// PURPOSE
//   Sequential shift-and-add unsigned multiplier: o_product = i_multiplicand * i_multiplier.
//   Retires one multiplier bit per clock using a single 2N-bit add.
//   Sits upstream of the arithmetic consumers. Valid/ready on both sides, one operation in flight.
// PARAMETERS
//   N  8  operand width in bits; N >= 2; product is 2N bits
// PORTS
//   i_clock         in   1   single clock; all state updates on rising edge
//   i_reset         in   1   synchronous, active-high reset
//   i_valid         in   1   operand pair offered
//   o_ready         out  1   block accepts operands (high only in IDLE)
//   i_multiplicand  in   N   operand A, unsigned
//   i_multiplier    in   N   operand B, unsigned
//   o_valid         out  1   o_product valid, held until taken
//   i_ready         in   1   downstream takes o_product
//   o_product       out  2N  A*B, unsigned, exact (no overflow possible)
//   o_busy          out  1   high in BUSY or DONE
// BEHAVIOUR
//   - Registers: a_reg[2N-1:0] (shifted multiplicand), b_reg[N-1:0], p_reg[2N-1:0],
//     count[$clog2(N+1)-1:0], 2-bit state.
//   - Reset (i_reset=1 at edge): state=IDLE, all registers 0. This gives o_ready=1,
//     o_valid=0, o_busy=0, o_product=0. Reset wins over every other event, including mid-BUSY:
//     the operation is discarded and no o_valid is produced.
//   - IDLE: o_ready=1. On i_valid&o_ready: a_reg={N'b0,A}, b_reg=B, p_reg=0, count=0 -> BUSY.
//   - BUSY: o_ready=0. Each cycle:
//       if b_reg[0], p_reg <= p_reg + a_reg (2N-bit add, carry discarded; cannot overflow).
//       Then a_reg <= a_reg<<1, b_reg <= b_reg>>1, count++.
//     The update in which count goes N-1 -> N also goes -> DONE.
//   - DONE: o_valid=1, o_product=p_reg stable. On i_ready -> IDLE. o_ready rises the cycle after.
//     No same-cycle accept-on-retire.
//   - Latency: accept at edge 0; o_valid high from cycle N+1 (N BUSY cycles). Throughput 1 per N+2 cycles.
//   - i_valid or operand changes outside IDLE are ignored. Operands are sampled only at accept.
//   - i_ready outside DONE has no effect. i_ready high on the DONE entry cycle retires on the next edge.
//   - o_product reads p_reg in all states. It is meaningful only while o_valid=1.
//   - Boundaries: A=0 or B=0 -> product 0. A=B=2^N-1 -> (2^N-1)^2, top bit of the 2N result exercised.
// CONFIGURATION
//   SERIAL_MULTIPLIER_EARLY_TERMINATE_EN
//     Defined: BUSY also exits to DONE when the shifted b_reg becomes 0 after the update.
//       B=0 -> 1 BUSY cycle.
//       Otherwise BUSY cycles = index of B's highest set bit + 1.
//       The result is identical to the undefined case, because the left-shift algorithm
//       needs no realignment.
//     Undefined: fixed N BUSY cycles regardless of operands. count is the only exit condition.
// STRUCTURE
//   - Shared package serial_multiplier_pkg:
//     state encoding localparams STATE_IDLE=2'd0, STATE_BUSY=2'd1, STATE_DONE=2'd2.
//     The value 2'd3 is illegal and recovers to IDLE.
//     Also the count-width function clog2.
//   - Sub-module serial_multiplier_control: FSM plus count. Inputs: handshake signals and b_zero.
//     Outputs: load, step, o_ready, o_valid, o_busy.
//     The datapath (registers, adder, shifts) stays in the top module.
// TESTING (N=8 unless noted)
//   - 13*11, i_ready=1 -> o_valid at cycle 9 after accept, o_product=143, o_valid high 1 cycle.
//   - 255*255 -> o_product=65025 (16'hFE01). 0*200 and 200*0 -> 0.
//   - Backpressure: 7*9, hold i_ready=0 for 5 cycles in DONE -> o_product=63 stable,
//     o_ready=0 throughout. Retire on i_ready=1, o_ready=1 the next cycle.
//   - Reset mid-op: assert i_reset at BUSY count=4 -> next cycle o_ready=1, o_valid=0,
//     o_product=0. A following 3*5 yields 15.
//   - Operands change and i_valid toggles during BUSY -> result unaffected (6*7=42).
//   - EARLY_TERMINATE_EN: 200*3 -> 2 BUSY cycles, 600. 200*0 -> 1 BUSY cycle, 0.
//     200*128 -> 8 BUSY cycles, 25600. Plus random compare vs A*B in both builds.

Source files
------------

// File: rtl/serial_multiplier_pkg.sv
// Shared state encoding and width helper for the serial multiplier.
// Build option SERIAL_MULTIPLIER_EARLY_TERMINATE_EN is consumed by serial_multiplier_control.
package serial_multiplier_pkg;

    localparam logic [1:0] STATE_IDLE = 2'd0;
    localparam logic [1:0] STATE_BUSY = 2'd1;
    localparam logic [1:0] STATE_DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = STATE_IDLE,
        ST_BUSY    = STATE_BUSY,
        ST_DONE    = STATE_DONE,
        ST_ILLEGAL = 2'd3
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_multiplier_control.sv
// Sequencer for the serial multiplier: IDLE -> BUSY (one bit per cycle) -> DONE -> IDLE.
// SERIAL_MULTIPLIER_EARLY_TERMINATE_EN lets BUSY exit once the remaining multiplier bits are zero.
module serial_multiplier_control
    import serial_multiplier_pkg::*;
#(
    parameter int N = 8
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_valid,
    input  logic i_ready,
    input  logic b_zero,
    output logic load,
    output logic step,
    output logic o_ready,
    output logic o_valid,
    output logic o_busy
);

    localparam int CW = clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] count;
    logic          finish;

`ifdef SERIAL_MULTIPLIER_EARLY_TERMINATE_EN
    assign finish = (count == LAST) || b_zero;
`else
    logic unused_b_zero;
    assign unused_b_zero = b_zero;
    assign finish        = (count == LAST);
`endif

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state <= ST_IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            if (load) begin
                count <= '0;
            end else if (step) begin
                count <= count + CW'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        o_ready    = 1'b0;
        o_valid    = 1'b0;
        o_busy     = 1'b0;
        case (state)
            ST_IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    load       = 1'b1;
                    state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                o_busy = 1'b1;
                step   = 1'b1;
                if (finish) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                o_valid = 1'b1;
                o_busy  = 1'b1;
                if (i_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/serial_multiplier.sv
// Shift-and-add unsigned multiplier, one multiplier bit per cycle, valid/ready on both sides.
// Latency N+1 cycles to o_valid (fewer with SERIAL_MULTIPLIER_EARLY_TERMINATE_EN); result held until taken.
module serial_multiplier
    import serial_multiplier_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           i_clock,
    input  logic           i_reset,
    input  logic           i_valid,
    output logic           o_ready,
    input  logic [N-1:0]   i_multiplicand,
    input  logic [N-1:0]   i_multiplier,
    output logic           o_valid,
    input  logic           i_ready,
    output logic [2*N-1:0] o_product,
    output logic           o_busy
);

    logic [2*N-1:0] a_reg;
    logic [N-1:0]   b_reg;
    logic [2*N-1:0] p_reg;
    logic           load;
    logic           step;
    logic           b_zero;

    // Multiplier is exhausted once the bits left after this cycle's shift are all zero.
    assign b_zero    = ~|b_reg[N-1:1];
    assign o_product = p_reg;

    serial_multiplier_control #(.N(N)) u_control (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .b_zero  (b_zero),
        .load    (load),
        .step    (step),
        .o_ready (o_ready),
        .o_valid (o_valid),
        .o_busy  (o_busy)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            a_reg <= '0;
            b_reg <= '0;
            p_reg <= '0;
        end else if (load) begin
            a_reg <= {{N{1'b0}}, i_multiplicand};
            b_reg <= i_multiplier;
            p_reg <= '0;
        end else if (step) begin
            if (b_reg[0]) begin
                p_reg <= p_reg + a_reg;
            end
            a_reg <= a_reg << 1;
            b_reg <= b_reg >> 1;
        end
    end

endmodule
